// File: rtl/psum_deskew_collector.sv
// psum_deskew_collector
// Re-aligns the diagonally skewed partial-sum lanes of an ARRAY_SIZE x ARRAY_SIZE
// PE array with per-lane delay lines, then queues each aligned result column in
// an output FIFO drained over a valid/ready handshake.
// Optional build macro PSUM_DESKEW_COL_IDX_EN adds out_col_idx (column index of
// the FIFO head entry).
module psum_deskew_collector #(
  parameter int ARRAY_SIZE = 8,
  parameter int PSUM_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ARRAY_SIZE*PSUM_WIDTH-1:0] psum_in,
  output logic [ARRAY_SIZE*PSUM_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
`ifdef PSUM_DESKEW_COL_IDX_EN
  output logic [$clog2(ARRAY_SIZE)-1:0]    out_col_idx,
`endif
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int unsigned DW   = ARRAY_SIZE * PSUM_WIDTH;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(2 * ARRAY_SIZE);

  // The counter is loaded with 0 on the start edge T, so on edge T+k it holds
  // k-1; column c (pushed on edge T+ARRAY_SIZE-1+c) sees r_cnt = c+ARRAY_SIZE-2.
  localparam logic [CW-1:0]   FIRST_CNT = CW'(ARRAY_SIZE - 2);
  localparam logic [CW-1:0]   LAST_CNT  = CW'(2 * ARRAY_SIZE - 3);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  // ---------------------------------------------------------------------------
  // Deskew delay lines: lane i is delayed by ARRAY_SIZE-1-i clocks
  // ---------------------------------------------------------------------------
  logic [DW-1:0] w_aligned;

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    localparam int unsigned DEPTH = ARRAY_SIZE - 1 - gi;
    if (DEPTH == 0) begin : g_pass
      assign w_aligned[gi*PSUM_WIDTH +: PSUM_WIDTH] = psum_in[gi*PSUM_WIDTH +: PSUM_WIDTH];
    end else begin : g_dly
      localparam int unsigned SRW = DEPTH * PSUM_WIDTH;
      // stage 0 sits in the low bits; the oldest sample is at the top
      logic [SRW-1:0] r_sr;

      // shift this lane by one stage every clock, regardless of FSM state
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_sr <= '0;
        end else begin
          r_sr <= SRW'({r_sr, psum_in[gi*PSUM_WIDTH +: PSUM_WIDTH]});
        end
      end

      assign w_aligned[gi*PSUM_WIDTH +: PSUM_WIDTH] = r_sr[SRW-1 -: PSUM_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Collection FSM
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_overflow;

  // FIFO state (declared here because the FSM needs the drop indication)
  logic [DW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [DW-1:0]   r_out_data;

  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;
  logic [CNTW-1:0] w_count_nxt;
  logic [AW-1:0]   w_rd_nxt;
  logic            w_head_bypass;

  assign w_push = (r_state == S_COLLECT) && (r_cnt >= FIRST_CNT) && (r_cnt <= LAST_CNT);

  // state, column counter and the registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_COLLECT;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && out_ready;
  assign w_wr     = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  assign w_count_nxt = r_count + CNTW'(w_wr) - CNTW'(w_pop);
  assign w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  // the next head is the entry being written this cycle when nothing else
  // remains after the pop, so it must come from w_aligned, not storage
  assign w_head_bypass = w_empty || ((r_count == CNTW'(1)) && w_pop);

  // storage write; entries are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_aligned;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // registered head-of-queue data; holds its last value while the FIFO is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data <= '0;
    end else if (w_count_nxt != '0) begin
      r_out_data <= w_head_bypass ? w_aligned : r_mem[w_rd_nxt];
    end
  end

`ifdef PSUM_DESKEW_COL_IDX_EN
  localparam int unsigned IW = $clog2(ARRAY_SIZE);

  logic [IW-1:0] r_mem_idx [FIFO_DEPTH];
  logic [IW-1:0] r_out_idx;
  logic [IW-1:0] w_col_idx;

  assign w_col_idx = IW'(r_cnt - FIRST_CNT);

  // column index stored alongside each FIFO entry
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_idx[r_wr_ptr] <= w_col_idx;
    end
  end

  // registered head-of-queue column index, same update rule as out_data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_idx <= '0;
    end else if (w_count_nxt != '0) begin
      r_out_idx <= w_head_bypass ? w_col_idx : r_mem_idx[w_rd_nxt];
    end
  end

  assign out_col_idx = r_out_idx;
`endif

  assign out_data  = r_out_data;
  assign out_valid = !w_empty;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule
